// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage: widths, NOP encoding and fetch FSM states.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int ILEN_BYTES = 4;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: PC/redirect in, imem request/response, decode handshake, next-PC enable.
// if_exc exists only when FETCH_MISALIGN_CHECK_EN is defined.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic [XLEN-1:0] pc;
  logic            redirect;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;
  logic            id_ready;
  logic            pc_we;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            if_exc;
`endif

  modport master (
`ifdef FETCH_MISALIGN_CHECK_EN
    output if_exc,
`endif
    input  pc, redirect, imem_ready, imem_rvalid, imem_rdata, id_ready,
    output imem_req, imem_addr, if_valid, if_pc, if_inst, pc_we
  );

  modport slave (
`ifdef FETCH_MISALIGN_CHECK_EN
    input  if_exc,
`endif
    output pc, redirect, imem_ready, imem_rvalid, imem_rdata, id_ready,
    input  imem_req, imem_addr, if_valid, if_pc, if_inst, pc_we
  );

endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage between the PC register and decode.
// FETCH_MISALIGN_CHECK_EN: misaligned PCs skip the memory and present an exception to decode.
module fetch_unit
  import cpu_pkg::*;
(
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

`ifdef NOP_ON_RESET
  localparam logic [XLEN-1:0] RST_INST = NOP_INST;
`else
  localparam logic [XLEN-1:0] RST_INST = '0;
`endif

  fetch_state_t    state;
  logic            discard;
  logic            addr_held;
  logic [XLEN-1:0] addr_hold;
  logic [XLEN-1:0] req_addr;
  logic            misalign;
  logic            valid_q;
  logic            exc_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_q;

  // A pending request keeps its address even if the PC register moves underneath it.
  assign req_addr = addr_held ? addr_hold : bus.pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign   = (bus.pc[1:0] != 2'b00) && !addr_held;
  assign bus.if_exc = exc_q;
`else
  assign misalign   = 1'b0;
`endif

  assign bus.imem_req  = (state == FS_REQ) && !misalign;
  assign bus.imem_addr = req_addr;
  assign bus.if_valid  = valid_q;
  assign bus.if_pc     = pc_q;
  assign bus.if_inst   = inst_q;
  assign bus.pc_we     = (state == FS_HOLD) && bus.id_ready && !bus.redirect && !exc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FS_REQ;
      discard   <= 1'b0;
      addr_held <= 1'b0;
      addr_hold <= '0;
      valid_q   <= 1'b0;
      exc_q     <= 1'b0;
      pc_q      <= '0;
      inst_q    <= RST_INST;
    end else begin
      case (state)
        FS_REQ: begin
          if (misalign) begin
            // A redirect means this PC is already stale; wait for the target instead.
            if (!bus.redirect) begin
              valid_q <= 1'b1;
              exc_q   <= 1'b1;
              pc_q    <= bus.pc;
              inst_q  <= '0;
              state   <= FS_HOLD;
            end
          end else if (bus.imem_ready) begin
            pc_q      <= req_addr;
            discard   <= bus.redirect || addr_held;
            addr_held <= 1'b0;
            state     <= FS_WAIT;
          end else if (bus.redirect && !addr_held) begin
            addr_held <= 1'b1;
            addr_hold <= bus.pc;
          end
        end
        FS_WAIT: begin
          if (bus.imem_rvalid) begin
            if (discard || bus.redirect) begin
              discard <= 1'b0;
              state   <= FS_REQ;
            end else begin
              inst_q  <= bus.imem_rdata;
              valid_q <= 1'b1;
              state   <= FS_HOLD;
            end
          end else if (bus.redirect) begin
            discard <= 1'b1;
          end
        end
        FS_HOLD: begin
          if (bus.redirect || bus.id_ready) begin
            valid_q <= 1'b0;
            exc_q   <= 1'b0;
            state   <= FS_REQ;
          end
        end
        default: state <= FS_REQ;
      endcase
    end
  end

  // Read data is only meaningful while a request is outstanding.
  a_rvalid_in_wait: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rvalid |-> (state == FS_WAIT));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a randomized run
// against a PC-register / memory reference model with a decode-side scoreboard.
module tb_fetch_unit;
  import cpu_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } exp_t;

`ifdef NOP_ON_RESET
  localparam logic [31:0] RST_INST = 32'h0000_0013;
`else
  localparam logic [31:0] RST_INST = 32'h0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  fetch_unit_if bus ();
  fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic get_exc;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign get_exc = bus.if_exc;
`else
  assign get_exc = 1'b0;
`endif

  // Decode-side monitor: handshakes against the scoreboard, plus per-cycle protocol rules.
  logic        prev_req_wait = 1'b0;
  logic [31:0] prev_addr;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc, prev_inst;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("pc_we", {31'd0, bus.pc_we},
          {31'd0, bus.if_valid && bus.id_ready && !bus.redirect && !get_exc});
      if (bus.if_valid && bus.id_ready && !bus.redirect) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_handshake: got pc %h inst %h expected no instruction",
                   bus.if_pc, bus.if_inst);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", bus.if_pc, e.pc);
          chk("sb_inst", bus.if_inst, e.inst);
          chk("sb_exc", {31'd0, get_exc}, {31'd0, e.exc});
        end
      end
      if (prev_req_wait) begin
        chk("req_held", {31'd0, bus.imem_req}, 32'd1);
        chk("addr_stable", bus.imem_addr, prev_addr);
      end
      if (prev_hold) begin
        chk("hold_valid", {31'd0, bus.if_valid}, 32'd1);
        chk("hold_pc", bus.if_pc, prev_pc);
        chk("hold_inst", bus.if_inst, prev_inst);
      end
    end
    prev_req_wait = !rst && bus.imem_req && !bus.imem_ready;
    prev_addr     = bus.imem_addr;
    prev_hold     = !rst && bus.if_valid && !bus.id_ready && !bus.redirect;
    prev_pc       = bus.if_pc;
    prev_inst     = bus.if_inst;
  end

  initial begin
    logic        s_adv, s_redir, s_acc, s_rv;
    logic [31:0] s_addr, tgt, maddr;
    logic        pending;
    int          lat, delivered;

    rst = 1'b1;
    bus.pc = 32'h0; bus.redirect = 1'b0; bus.imem_ready = 1'b0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0; bus.id_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_if_inst", bus.if_inst, RST_INST);
    chk("rst_pc_we", {31'd0, bus.pc_we}, 32'd0);
    chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd1);
    chk("rst_get_exc", {31'd0, get_exc}, 32'd0);

    // Zero-wait fetch at pc=0
    tick();
    rst = 1'b0; bus.imem_ready = 1'b1; bus.id_ready = 1'b1; bus.imem_rdata = 32'h0050_0093;
    exp_q.push_back('{32'h0, 32'h0050_0093, 1'b0});
    @(negedge clk);
    chk("t1_c0_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t1_c0_addr", bus.imem_addr, 32'h0);
    tick();
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b1;
    @(negedge clk);
    chk("t1_c1_valid", {31'd0, bus.if_valid}, 32'd0);
    tick();
    bus.imem_rvalid = 1'b0;
    @(negedge clk);
    chk("t1_c2_valid", {31'd0, bus.if_valid}, 32'd1);
    chk("t1_c2_pc", bus.if_pc, 32'h0);
    chk("t1_c2_inst", bus.if_inst, 32'h0050_0093);
    chk("t1_c2_pc_we", {31'd0, bus.pc_we}, 32'd1);
    tick();
    bus.pc = 32'h10; bus.id_ready = 1'b0;

    // Memory stalls three cycles, then a five-cycle decode stall
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.imem_ready = 1'b1;
      @(negedge clk);
      chk("t2_req", {31'd0, bus.imem_req}, 32'd1);
      chk("t2_addr", bus.imem_addr, 32'h10);
      tick();
    end
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = mem_word(32'h10);
    exp_q.push_back('{32'h10, mem_word(32'h10), 1'b0});
    tick();
    bus.imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_valid", {31'd0, bus.if_valid}, 32'd1);
      chk("t4_pc", bus.if_pc, 32'h10);
      chk("t4_inst", bus.if_inst, mem_word(32'h10));
      chk("t4_pc_we", {31'd0, bus.pc_we}, 32'd0);
      tick();
    end
    bus.id_ready = 1'b1;
    @(negedge clk);
    chk("t4_pc_we_hi", {31'd0, bus.pc_we}, 32'd1);
    tick();
    bus.pc = 32'h20; bus.id_ready = 1'b0;
    @(negedge clk);
    chk("t4_pc_we_lo", {31'd0, bus.pc_we}, 32'd0);

    // Redirect while waiting for read data: the returned word must be dropped
    tick();
    bus.imem_ready = 1'b1;
    @(negedge clk);
    chk("t3_addr", bus.imem_addr, 32'h20);
    tick();
    bus.imem_ready = 1'b0; bus.redirect = 1'b1;
    tick();
    bus.redirect = 1'b0; bus.pc = 32'h100; bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF; bus.id_ready = 1'b1;
    @(negedge clk);
    chk("t3_no_valid_rv", {31'd0, bus.if_valid}, 32'd0);
    tick();
    bus.imem_rvalid = 1'b0;
    @(negedge clk);
    chk("t3_no_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("t3_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t3_new_addr", bus.imem_addr, 32'h100);
    exp_q.push_back('{32'h100, mem_word(32'h100), 1'b0});
    tick();
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = mem_word(32'h100);
    tick();
    bus.imem_rvalid = 1'b0;
    @(negedge clk);
    chk("t3_valid", {31'd0, bus.if_valid}, 32'd1);
    tick();
    bus.pc = 32'h104;

    // Asynchronous reset while a fetch is outstanding
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t5_addr", bus.imem_addr, 32'h104);
    chk("t5_valid", {31'd0, bus.if_valid}, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    bus.pc = 32'h6;
`endif
    tick();
    rst = 1'b0;

`ifdef FETCH_MISALIGN_CHECK_EN
    @(negedge clk);
    chk("t6_no_req", {31'd0, bus.imem_req}, 32'd0);
    tick();
    @(negedge clk);
    chk("t6_valid", {31'd0, bus.if_valid}, 32'd1);
    chk("t6_exc", {31'd0, bus.if_exc}, 32'd1);
    chk("t6_pc", bus.if_pc, 32'h6);
    chk("t6_inst", bus.if_inst, 32'h0);
    chk("t6_pc_we", {31'd0, bus.pc_we}, 32'd0);
    exp_q.push_back('{32'h6, 32'h0, 1'b1});
    tick();
    bus.id_ready = 1'b1;
    tick();
    bus.id_ready = 1'b0; bus.redirect = 1'b1;
    @(negedge clk);
    chk("t6_no_req2", {31'd0, bus.imem_req}, 32'd0);
    tick();
    bus.redirect = 1'b0; bus.pc = 32'h200;
`endif

    // Randomized run: the bench acts as PC register and memory
    exp_q.delete();
    exp_q.push_back('{bus.pc, mem_word(bus.pc), 1'b0});
    pending = 1'b0; lat = 0; maddr = 32'h0; tgt = 32'h0; delivered = 0;
    bus.id_ready = 1'b1;
    for (int cyc = 0; cyc < 5000 && delivered < 150; cyc++) begin
      @(negedge clk);
      s_adv   = bus.pc_we;
      s_redir = bus.redirect;
      s_acc   = bus.imem_req && bus.imem_ready;
      s_addr  = bus.imem_addr;
      s_rv    = bus.imem_rvalid;
      if (bus.if_valid && bus.id_ready && !bus.redirect) delivered++;
      tick();
      if (s_redir) bus.pc = tgt;
      else if (s_adv) bus.pc = bus.pc + 32'd4;
      if (s_redir || s_adv) begin
        exp_q.delete();
        exp_q.push_back('{bus.pc, mem_word(bus.pc), 1'b0});
      end
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom();
      if (s_rv) pending = 1'b0;
      if (s_acc) begin
        pending = 1'b1;
        lat     = $urandom_range(0, 3);
        maddr   = s_addr;
      end
      if (pending) begin
        if (lat == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word(maddr);
        end else begin
          lat--;
        end
      end
      bus.redirect   = !bus.redirect && ($urandom_range(0, 9) == 0);
      tgt            = $urandom() & 32'hFFFF_FFFC;
      bus.imem_ready = ($urandom_range(0, 2) != 0);
      bus.id_ready   = ($urandom_range(0, 2) != 0);
    end
    chk("random_deliveries", (delivered >= 150) ? 32'd1 : 32'd0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
